// File: rtl/scan_pkg.sv
// Shared types and constants for the decoder select-scanning blocks.
package scan_pkg;

  localparam int SEL_W         = 3;
  localparam int DWELL_DEFAULT = 4;
  localparam int LAST_DEFAULT  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  // Advance a select code, folding back to zero after the last code in use.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur,
                                                input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] nxt;
    nxt = '0;
    if (cur != last) begin
      nxt = cur + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts enabled cycles and flags the last cycle of a DWELL-cycle hold window.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  // The count folds to zero on the done cycle so it never passes DWELL-1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      if (cnt_q == CntLast) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign done_o = (cnt_q == CntLast);

endmodule

// File: rtl/scan_sel_gen.sv
// Drives decoder EN/select: each code 0..LAST is held for DWELL enabled cycles,
// followed by a one-cycle blanking gap so adjacent decoder outputs never touch.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT,
  parameter int LAST  = LAST_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic [SEL_W-1:0] load_sel_i,
  output logic             en_out_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             wrap_o,
  output logic             busy_o
);

  localparam logic [SEL_W-1:0] LastCode = SEL_W'(LAST);

  scan_state_e      state_q;
  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic             wrap_q;
  logic             busy_q;

  logic             timerClr;
  logic             timerInc;
  logic             timerDone;
  logic [SEL_W-1:0] selStep;
  logic [SEL_W-1:0] selLoad;

  assign timerClr = stop_i | (state_q != RUN);
  assign timerInc = (state_q == RUN);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (timerClr),
    .inc_i  (timerInc),
    .done_o (timerDone)
  );

  // Codes beyond LAST would select an unused decoder output, so they load as zero.
  always_comb begin
    selStep = next_sel(sel_q, LastCode);
    selLoad = load_sel_i;
    if (load_sel_i > LastCode) begin
      selLoad = '0;
    end
  end

  // sel only moves on the RUN->GAP edge, so it is stable whenever en_out is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (stop_i) begin
        state_q <= IDLE;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_i) begin
              sel_q <= selLoad;
            end
            if (start_i) begin
              state_q <= RUN;
              en_q    <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (timerDone) begin
              state_q <= GAP;
              en_q    <= 1'b0;
              sel_q   <= selStep;
              wrap_q  <= (sel_q == LastCode);
            end
          end
          GAP: begin
            state_q <= RUN;
            en_q    <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en_out_o = en_q;
  assign sel_o    = sel_q;
  assign wrap_o   = wrap_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: three parameterisations share one stimulus stream and
// are compared every cycle against a slot/phase reference model.
module tb_scan_sel_gen;

  localparam int NDUT = 3;
  localparam int D0 = 4, L0 = 7;
  localparam int D1 = 3, L1 = 5;
  localparam int D2 = 1, L2 = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, load;
  logic [2:0] loadSel;

  logic       enOut   [NDUT];
  logic [2:0] selOut  [NDUT];
  logic       wrapOut [NDUT];
  logic       busyOut [NDUT];

  int testCount = 0;
  int failCount = 0;

  int mDwell   [NDUT] = '{D0, D1, D2};
  int mLast    [NDUT] = '{L0, L1, L2};
  bit mRunning [NDUT];
  int mPhase   [NDUT];
  int mSel     [NDUT];
  bit mWrap    [NDUT];

  always #5 clk = ~clk;

  scan_sel_gen #(.DWELL(D0), .LAST(L0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .load_i(load),
    .load_sel_i(loadSel), .en_out_o(enOut[0]), .sel_o(selOut[0]),
    .wrap_o(wrapOut[0]), .busy_o(busyOut[0]));

  scan_sel_gen #(.DWELL(D1), .LAST(L1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .load_i(load),
    .load_sel_i(loadSel), .en_out_o(enOut[1]), .sel_o(selOut[1]),
    .wrap_o(wrapOut[1]), .busy_o(busyOut[1]));

  scan_sel_gen #(.DWELL(D2), .LAST(L2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .load_i(load),
    .load_sel_i(loadSel), .en_out_o(enOut[2]), .sel_o(selOut[2]),
    .wrap_o(wrapOut[2]), .busy_o(busyOut[2]));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] decode38(input logic en, input logic [2:0] s);
    return en ? (8'b1 << s) : 8'h00;
  endfunction

  // A code occupies DWELL+1 slots: phases 0..DWELL-1 enabled, phase DWELL blanked.
  function automatic bit expEn(input int i);
    return mRunning[i] && (mPhase[i] < mDwell[i]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NDUT; i++) begin
      mRunning[i] = 1'b0;
      mPhase[i]   = 0;
      mSel[i]     = 0;
      mWrap[i]    = 1'b0;
    end
  endtask

  task automatic modelStep(input int i);
    mWrap[i] = 1'b0;
    if (stop) begin
      mRunning[i] = 1'b0;
      mPhase[i]   = 0;
    end else if (!mRunning[i]) begin
      if (load) mSel[i] = (int'(loadSel) > mLast[i]) ? 0 : int'(loadSel);
      if (start) begin
        mRunning[i] = 1'b1;
        mPhase[i]   = 0;
      end
    end else if (mPhase[i] == mDwell[i]) begin
      mPhase[i] = 0;
    end else if (mPhase[i] == mDwell[i] - 1) begin
      mPhase[i] = mDwell[i];
      mWrap[i]  = (mSel[i] == mLast[i]);
      mSel[i]   = mWrap[i] ? 0 : (mSel[i] + 1) % 8;
    end else begin
      mPhase[i]++;
    end
  endtask

  task automatic compareAll(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("%s.en%0d", tag, i), enOut[i], expEn(i));
      checkOutput($sformatf("%s.sel%0d", tag, i), selOut[i], mSel[i]);
      checkOutput($sformatf("%s.wrap%0d", tag, i), wrapOut[i], mWrap[i]);
      checkOutput($sformatf("%s.busy%0d", tag, i), busyOut[i], mRunning[i]);
      checkOutput($sformatf("%s.dec%0d", tag, i), decode38(enOut[i], selOut[i]),
                  decode38(expEn(i), 3'(mSel[i])));
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic ld,
                               input logic [2:0] ls, input string tag);
    @(negedge clk);
    start   = st;
    stop    = sp;
    load    = ld;
    loadSel = ls;
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) modelStep(i);
    #1;
    compareAll(tag);
  endtask

  initial begin
    int firstWrap;
    int wrapCount;

    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; loadSel = 3'd0;
    modelReset();
    #1;
    checkOutput("resetEn", enOut[0], 0);
    checkOutput("resetSel", selOut[0], 0);
    checkOutput("resetBusy", busyOut[0], 0);
    checkOutput("resetWrap", wrapOut[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic sweep from reset, plus DWELL=1/LAST=0 toggling on dut2.
    applyStimulus(1, 0, 0, 0, "sweepStart");
    checkOutput("sweepFirstSel", selOut[0], 0);
    checkOutput("sweepFirstEn", enOut[0], 1);
    firstWrap = -1;
    wrapCount = 0;
    for (int k = 2; k <= 90; k++) begin
      applyStimulus(0, 0, 0, 0, "sweep");
      if (wrapOut[0]) begin
        wrapCount++;
        if (firstWrap < 0) firstWrap = k;
      end
      if (k <= 8) begin
        checkOutput("boundEn", enOut[2], (k % 2 == 1) ? 1 : 0);
        checkOutput("boundWrap", wrapOut[2], (k % 2 == 0) ? 1 : 0);
        checkOutput("boundSel", selOut[2], 0);
      end
    end
    checkOutput("sweepWrapCycle", firstWrap, 40);
    checkOutput("sweepWrapCount", wrapCount, 2);
    applyStimulus(0, 1, 0, 0, "sweepStop");

    // Load then start resumes on the loaded code.
    applyStimulus(0, 0, 1, 6, "load6");
    applyStimulus(1, 0, 0, 0, "load6Start");
    checkOutput("load6Sel", selOut[0], 6);
    firstWrap = -1;
    for (int k = 2; k <= 12; k++) begin
      applyStimulus(0, 0, 0, 0, "load6Run");
      if (wrapOut[0] && firstWrap < 0) firstWrap = k;
    end
    checkOutput("load6WrapCycle", firstWrap, 10);
    applyStimulus(0, 1, 0, 0, "load6Stop");
    applyStimulus(0, 0, 1, 7, "load7");
    checkOutput("load7Last7", selOut[0], 7);
    checkOutput("load7Last5", selOut[1], 0);

    // Stop beats start and load while running at code 3.
    applyStimulus(1, 0, 1, 3, "stopPrepare");
    applyStimulus(0, 0, 0, 0, "stopRun");
    applyStimulus(1, 1, 1, 6, "stopAll");
    checkOutput("stopSel", selOut[0], 3);
    checkOutput("stopEn", enOut[0], 0);
    checkOutput("stopBusy", busyOut[0], 0);
    applyStimulus(0, 0, 0, 0, "stopIdle");

    // Asynchronous reset mid-run at code 5.
    applyStimulus(1, 0, 1, 5, "rstPrepare");
    applyStimulus(0, 0, 0, 0, "rstRun");
    checkOutput("preRstSel", selOut[0], 5);
    checkOutput("preRstEn", enOut[0], 1);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("asyncEn%0d", i), enOut[i], 0);
      checkOutput($sformatf("asyncSel%0d", i), selOut[i], 0);
      checkOutput($sformatf("asyncWrap%0d", i), wrapOut[i], 0);
      checkOutput($sformatf("asyncBusy%0d", i), busyOut[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0, 0, "postRstIdle");
    checkOutput("postRstBusy", busyOut[0], 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(99) < 20), ($urandom_range(99) < 3),
                    ($urandom_range(99) < 15), 3'($urandom_range(7)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/scan_sel_gen.md
# scan_sel_gen

Sequential select generator that drives the enable and 3-bit select inputs of the 3-to-8 decoder stage. It steps a registered select code through 0..LAST, holds each code for DWELL cycles with the enable high, and inserts a one-cycle blanking gap between codes so two decoder outputs never go high in consecutive cycles. It is used for digit/LED scanning and for sequential walking of register-file write strobes in the lab datapath.

## Interface
- DWELL, default 4: cycles the enable stays high per select code; legal range 1..255.
- LAST, default 7: highest select code before wrap; legal range 0..7.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled each edge; begins or resumes scanning.
- stop  in  1  level, sampled each edge; returns to IDLE, priority over start and load.
- load  in  1  loads load_sel into the select register, accepted only in IDLE.
- load_sel  in  3  code to load.
- en_out  out  1  registered; connects to decoder EN.
- sel  out  3  registered; sel[2] to Ip2, sel[1] to Ip1, sel[0] to Ip0.
- wrap  out  1  registered one-cycle pulse when sel wraps LAST->0.
- busy  out  1  registered; high in RUN and GAP.

## Operation
- States: IDLE, RUN, GAP.
- Reset (asynchronous, immediate): state=IDLE, sel=0, en_out=0, wrap=0, busy=0, dwell count=0.
- IDLE: en_out=0, sel holds.
  - load=1: sel<=load_sel; if load_sel>LAST, sel<=0.
  - start=1: go to RUN, dwell count<=0.
  - load and start together: the load is applied and RUN starts on the loaded code.
- RUN: en_out=1, busy=1. Dwell count increments each cycle.
  - When count==DWELL-1: go to GAP, count<=0, sel<=sel+1.
  - If sel==LAST, sel<=0 and wrap pulses instead.
- GAP: en_out=0, busy=1, exactly one cycle, then go to RUN unconditionally.
- stop=1 in any state: next state is IDLE, en_out<=0, busy<=0, sel holds its current value, count<=0. A pending increment from the same edge is discarded.
- start while in RUN or GAP has no effect. load outside IDLE is ignored.
- LAST=0: sel stays 0 and wrap pulses on every RUN->GAP transition.
- Arithmetic: the dwell counter is $clog2(DWELL+1) bits wide, unsigned, and never exceeds DWELL-1. The sel increment is 3-bit, with an explicit compare against LAST; there is no reliance on natural overflow.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- start sampled at edge n: en_out=1 and busy=1 from edge n (visible in cycle n+1).
- Each code sees DWELL cycles of en_out=1 followed by 1 cycle of en_out=0. sel changes on the same edge that en_out falls, so sel is stable whenever en_out=1.
- Full sweep: (LAST+1)*(DWELL+1) cycles.
- wrap is high in the first GAP cycle after code LAST, i.e. the same cycle that sel shows 0.
- stop sampled at edge n: en_out=0 from edge n.
- rst asserted mid-scan: outputs clear immediately, without waiting for clk. Scanning does not resume after rst deasserts until a new start.

## Structure
- Shared package scan_pkg:
  - state enum (IDLE, RUN, GAP) with 2-bit encoding;
  - SEL_W=3;
  - default DWELL/LAST constants.
- Sub-module dwell_timer: parameterised DWELL, with inputs clr and inc and output done (count==DWELL-1). It is reused by later display-scan blocks.
- The top level holds the FSM, the sel register, and the wrap/busy flops.

## Test plan
- Reset: assert rst mid-RUN with sel=5 -> en_out, sel, wrap and busy are all 0 without a clock edge; no activity after deassert until start.
- Basic sweep, DWELL=4, LAST=7: start one cycle -> sel 0..7 each with en_out high 4 cycles then low 1 cycle; wrap pulses once at cycle 40 with sel=0; the sequence repeats.
- Load: in IDLE, load=1 with load_sel=6, then start -> RUN begins at sel=6 and wraps after 6, 7. load_sel=7 with LAST=5 -> sel=0.
- Stop priority: stop, start and load all high in RUN at sel=3 -> IDLE, sel stays 3, en_out=0, and load is ignored.
- Boundary: DWELL=1, LAST=0 -> en_out toggles 1,0,1,0, sel stays 0, wrap pulses every GAP.
- Decoder integration: drive decoder38 from en_out/sel -> exactly one Op high per RUN cycle, the sequence Op0..Op7 appears, and all Op are low in GAP and IDLE.
